// File: rtl/hcp_pipe_adder_if.sv
// Handshake and data bundle for hcp_pipe_adder: the producer side drives
// operands and the consumer ready, the adder drives results and accept ready.
interface hcp_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op;
    logic             cout;
    logic             ovf;

    // Producer / consumer side (testbench or surrounding PE logic)
    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, op, cout, ovf
    );

    // Adder side
    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, op, cout, ovf
    );
endinterface

// File: rtl/hcp_pipe_adder.sv
// Segment-pipelined hybrid carry-propagate adder/subtractor.
// Each stage resolves SEG bits and registers its carry into the next stage;
// the last stage also forms cout/ovf and optionally saturates. All stages
// advance together on adv, so a full output with no taker freezes the pipe.
module hcp_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int SAT   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    hcp_pipe_adder_if.slave    bus
);

    localparam int NSEG = WIDTH / SEG;
    localparam int NREG = (NSEG > 1) ? NSEG - 1 : 1;

    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_cfg
        $error("hcp_pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    // Clamp to the signed extreme on the side the true result lies.
    // A wrapped result with MSB set means the true sum was positive.
    function automatic logic [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] r,
        input logic                    ovf
    );
        logic signed [WIDTH-1:0] res;
        res = r;
        if ((SAT != 0) && ovf) begin
            if (r[WIDTH-1]) res = {1'b0, {(WIDTH-1){1'b1}}};
            else            res = {1'b1, {(WIDTH-1){1'b0}}};
        end
        return res;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] y_cond;

    // Inter-stage registers: stage k holds resolved bits [ (k+1)*SEG-1 : 0 ],
    // its carry out, and the full skewed operands for the stages still ahead.
    logic             vld_p [NREG];
    logic             c_p   [NREG];
    logic [WIDTH-1:0] res_p [NREG];
    logic [WIDTH-1:0] xs_p  [NREG];
    logic [WIDTH-1:0] ys_p  [NREG];

    // Output register set (final stage)
    logic             vld_out;
    logic [WIDTH-1:0] op_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv    = ~vld_out | bus.out_ready;
    assign y_cond = bus.sub ? ~bus.y : bus.y;

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_out;
    assign bus.op        = op_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG-1:0]   seg_x;
        logic [SEG-1:0]   seg_y;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] res_nxt;
        logic [SEG:0]     seg_sum;

        // ---- stage k inputs: port operands for stage 0, skew regs otherwise;
        // the subtract "+1" enters as the stage-0 carry-in
        if (k == 0) begin : g_src
            assign seg_x  = bus.x[SEG-1:0];
            assign seg_y  = y_cond[SEG-1:0];
            assign c_in   = bus.sub;
            assign v_in   = bus.in_valid;
            assign res_in = '0;
        end else begin : g_src
            assign seg_x  = xs_p[k-1][k*SEG +: SEG];
            assign seg_y  = ys_p[k-1][k*SEG +: SEG];
            assign c_in   = c_p[k-1];
            assign v_in   = vld_p[k-1];
            assign res_in = res_p[k-1];
        end

        assign seg_sum = {1'b0, seg_x} + {1'b0, seg_y} + {{SEG{1'b0}}, c_in};

        // Splice this stage's segment into the already-resolved lower bits
        always_comb begin
            res_nxt                  = res_in;
            res_nxt[k*SEG +: SEG]    = seg_sum[SEG-1:0];
        end

        if (k < NSEG - 1) begin : g_reg
            logic [WIDTH-1:0] x_src;
            logic [WIDTH-1:0] y_src;

            if (k == 0) begin : g_skw
                assign x_src = bus.x;
                assign y_src = y_cond;
            end else begin : g_skw
                assign x_src = xs_p[k-1];
                assign y_src = ys_p[k-1];
            end

            // ---- stage k -> k+1 boundary: carry, partial result, skewed operands
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p[k] <= 1'b0;
                    c_p[k]   <= 1'b0;
                    res_p[k] <= '0;
                    xs_p[k]  <= '0;
                    ys_p[k]  <= '0;
                end else if (adv) begin
                    vld_p[k] <= v_in;
                    c_p[k]   <= seg_sum[SEG];
                    res_p[k] <= res_nxt;
                    xs_p[k]  <= x_src;
                    ys_p[k]  <= y_src;
                end
            end
        end else begin : g_out
            logic c_msb;
            logic cout_nxt;
            logic ovf_nxt;

            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c
            assign cout_nxt = seg_sum[SEG];
            assign c_msb    = seg_x[SEG-1] ^ seg_y[SEG-1] ^ seg_sum[SEG-1];
            assign ovf_nxt  = c_msb ^ cout_nxt;

            // ---- final stage -> output register (saturation lives only here)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_out <= 1'b0;
                    op_q    <= '0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end else if (adv) begin
                    vld_out <= v_in;
                    op_q    <= saturate(res_nxt, ovf_nxt);
                    cout_q  <= cout_nxt;
                    ovf_q   <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_hcp_pipe_adder.sv
// Bench for hcp_pipe_adder: three instances (16/4 wrap, 16/4 saturating,
// 32/8 wrap) share one handshake and run in lockstep; a per-instance queue
// holds expected results pushed on accept and checked while out_valid is high.
module tb_hcp_pipe_adder;

    typedef logic [33:0] res_t;   // {cout, ovf, op[31:0]}

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        logic [15:0] op;
        logic        c;
        logic        v;
        logic [15:0] op_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [31:0] x32;
    logic [31:0] y32;

    res_t cur_e0, cur_e1, cur_e2;
    res_t q0[$];
    res_t q1[$];
    res_t q2[$];
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl[12];

    always #5 clk = ~clk;

    hcp_pipe_adder_if #(.WIDTH(16)) bus0();
    hcp_pipe_adder_if #(.WIDTH(16)) bus1();
    hcp_pipe_adder_if #(.WIDTH(32)) bus2();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
    assign bus0.sub      = sub;       assign bus1.sub      = sub;       assign bus2.sub      = sub;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;
    assign bus0.x = x32[15:0];  assign bus0.y = y32[15:0];
    assign bus1.x = x32[15:0];  assign bus1.y = y32[15:0];
    assign bus2.x = x32;        assign bus2.y = y32;

    hcp_pipe_adder #(.WIDTH(16), .SEG(4), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    hcp_pipe_adder #(.WIDTH(16), .SEG(4), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    hcp_pipe_adder #(.WIDTH(32), .SEG(8), .SAT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic fail_msg(input string nm, input string why);
        n_total++;
        $display("FAIL %s: %s", nm, why);
    endtask

    // Reference from signed integer arithmetic, independent of segmenting
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input bit sat);
        longint mask, ua, ub, yy, sum, sa, sb, full, maxv, minv;
        logic [31:0] r;
        logic        c, v;
        mask = (longint'(1) << w) - 1;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(maxv + 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        yy   = s ? (~ub & mask) : ub;
        sum  = ua + yy + longint'(s);
        c    = sum[w];
        sa   = (ua > maxv) ? ua - (mask + 1) : ua;
        sb   = (ub > maxv) ? ub - (mask + 1) : ub;
        full = s ? sa - sb : sa + sb;
        v    = (full > maxv) || (full < minv);
        r    = 32'(sum & mask);
        if (sat && v) r = (full > 0) ? 32'(maxv) : 32'(minv & mask);
        return {c, v, r};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_8000;
            3:       return 32'h7FFF_7FFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboards: push on accept, compare head while valid, pop on drain
    always @(negedge clk) if (rst_n) begin
        if (in_valid && bus0.in_ready) q0.push_back(cur_e0);
        if (bus0.out_valid) begin
            if (q0.size() == 0) fail_msg("dut0_result", "result with no beat outstanding");
            else begin
                check("dut0_result", 40'({bus0.cout, bus0.ovf, 16'h0, bus0.op}), 40'(q0[0]));
                if (out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (in_valid && bus1.in_ready) q1.push_back(cur_e1);
        if (bus1.out_valid) begin
            if (q1.size() == 0) fail_msg("dut1_sat_result", "result with no beat outstanding");
            else begin
                check("dut1_sat_result", 40'({bus1.cout, bus1.ovf, 16'h0, bus1.op}), 40'(q1[0]));
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (in_valid && bus2.in_ready) q2.push_back(cur_e2);
        if (bus2.out_valid) begin
            if (q2.size() == 0) fail_msg("dut2_w32_result", "result with no beat outstanding");
            else begin
                check("dut2_w32_result", 40'({bus2.cout, bus2.ovf, bus2.op}), 40'(q2[0]));
                if (out_ready) void'(q2.pop_front());
            end
        end
    end

    // Present one beat and hold it until accepted; entered #1 after a posedge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input res_t e0, input res_t e1);
        bit acc = 1'b0;
        int t   = 0;
        x32 = a; y32 = b; sub = s;
        cur_e0 = e0; cur_e1 = e1; cur_e2 = model(32, a, b, s, 1'b0);
        in_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) fail_msg("send_accept", "beat not accepted within 200 cycles");
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0 || bus0.out_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check({nm, "_outstanding"}, 40'(q0.size() + q1.size() + q2.size()), 40'd0);
    endtask

    // Accept edge E, then out_valid must be low after E..E+2 and high after E+3
    task automatic latency_check(input string nm, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
        x32 = a; y32 = b; sub = s;
        cur_e0 = model(16, a, b, s, 1'b0);
        cur_e1 = model(16, a, b, s, 1'b1);
        cur_e2 = model(32, a, b, s, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 40'(bus0.in_ready), 40'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s_out_valid_e%0d", nm, n), 40'(bus0.out_valid), 40'(n == 3));
            if (n < 3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h5555};
        tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
        tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE};
        tbl[4]  = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0002};
        tbl[5]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h8000};
        tbl[6]  = '{16'h4000, 16'h1000, 1'b0, 16'h5000, 1'b0, 1'b0, 16'h5000};
        tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000};
        tbl[8]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
        tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[10] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h1000};
        tbl[11] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1, 16'h8000};

        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0;
        x32 = '0; y32 = '0; cur_e0 = '0; cur_e1 = '0; cur_e2 = '0;

        // Reset state, with out_ready low to show in_ready does not depend on it
        #12;
        check("reset_dut0", 40'({bus0.out_valid, bus0.in_ready, bus0.cout, bus0.ovf, bus0.op}),
              40'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0}));
        check("reset_dut2", 40'({bus2.out_valid, bus2.in_ready, bus2.cout, bus2.ovf, bus2.op}),
              40'({1'b0, 1'b1, 1'b0, 1'b0, 32'h0}));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 40'(bus0.in_ready), 40'd1);

        // Basic add latency
        latency_check("basic_add", 32'h0000_1234, 32'h0000_4321, 1'b0);
        wait_drain("basic_add");

        // Directed vectors streamed back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++)
            send({16'h0, tbl[i].x}, {16'h0, tbl[i].y}, tbl[i].s,
                 {tbl[i].c, tbl[i].v, 16'h0, tbl[i].op},
                 {tbl[i].c, tbl[i].v, 16'h0, tbl[i].op_sat});
        wait_drain("table");

        // Backpressure: 8 mixed beats, 5-cycle stall from the first out_valid
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] a, b;
                    a = rnd_val(); b = rnd_val();
                    send(a, b, 1'(i % 2), model(16, a, b, 1'(i % 2), 1'b0),
                         model(16, a, b, 1'(i % 2), 1'b1));
                end
                in_valid = 1'b0;
            end
            begin
                int t = 0;
                while (!bus0.out_valid && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (!bus0.out_valid) fail_msg("stall_start", "no out_valid within 50 cycles");
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check($sformatf("stall_in_ready_c%0d", i), 40'(bus0.in_ready), 40'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Reset asserted while beats are in flight and a result is valid
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a, b;
            a = rnd_val(); b = rnd_val();
            send(a, b, 1'(i % 2), model(16, a, b, 1'(i % 2), 1'b0), model(16, a, b, 1'(i % 2), 1'b1));
        end
        in_valid = 1'b0;
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("midreset_dut0", 40'({bus0.out_valid, bus0.in_ready, bus0.cout, bus0.ovf, bus0.op}),
              40'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0}));
        check("midreset_dut1", 40'({bus1.out_valid, bus1.in_ready, bus1.cout, bus1.ovf, bus1.op}),
              40'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0}));
        check("midreset_dut2", 40'({bus2.out_valid, bus2.in_ready, bus2.cout, bus2.ovf, bus2.op}),
              40'({1'b0, 1'b1, 1'b0, 1'b0, 32'h0}));
        q0.delete(); q1.delete(); q2.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        latency_check("after_reset", 32'h0123_00FF, 32'h0456_0F01, 1'b1);
        wait_drain("after_reset");

        // Random traffic with random bubbles and random backpressure
        begin
            int acc_n = 0;
            int cyc   = 0;
            bit done;
            in_valid = 1'b0;
            while (acc_n < 10000 && cyc < 60000) begin
                if (!in_valid && $urandom_range(3) != 0) begin
                    logic [31:0] a, b;
                    logic        s;
                    a = rnd_val(); b = rnd_val(); s = 1'($urandom_range(1));
                    x32 = a; y32 = b; sub = s;
                    cur_e0 = model(16, a, b, s, 1'b0);
                    cur_e1 = model(16, a, b, s, 1'b1);
                    cur_e2 = model(32, a, b, s, 1'b0);
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(3) != 0);
                @(negedge clk);
                done = in_valid && bus0.in_ready;
                if (done) acc_n++;
                @(posedge clk); #1;
                cyc++;
                if (done) in_valid = 1'b0;
            end
            if (acc_n < 10000) fail_msg("random_accept", "random beats not all accepted in cycle budget");
        end
        wait_drain("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
